// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: 3-sample mid-bit majority vote, start/parity/stop checks, deserializer strobes.
// Strobes are combinational from registered state; DataValid trails OutData by one cycle. Parity logic exists only with PARITY_CHECK_EN.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       SampledBit,
  output logic       DeserEn,
  output logic       OutData,
  output logic       DataValid,
  output logic       ParErr,
  output logic       StpErr
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [5:0]    e_q, e_d;
  logic [5:0]    p_q, p_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          s0_q, s0_d;
  logic          s1_q, s1_d;
  logic          sb_q, sb_d;
  logic          err_q, err_d;
  logic          dv_q, dv_d;

`ifdef PARITY_CHECK_EN
  logic          acc_q, acc_d;
  logic          par_en_q, par_en_d;
  logic          par_typ_q, par_typ_d;
`else
  logic          unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  logic [5:0] p_eff;
  logic [5:0] half;
  logic [5:0] last;
  logic       mid;
  logic       end_bit;

  assign p_eff   = ((Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32))
                   ? Prescale : 6'd8;
  assign half    = p_q >> 1;
  assign last    = p_q - 6'd1;
  assign mid     = (e_q == half + 6'd2);
  assign end_bit = (e_q == last);

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    p_d     = p_q;
    bit_d   = bit_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    sb_d    = sb_q;
    err_d   = err_q;
    DeserEn = 1'b0;
    OutData = 1'b0;
    ParErr  = 1'b0;
    StpErr  = 1'b0;
`ifdef PARITY_CHECK_EN
    acc_d     = acc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
`endif

    if (state_q != IDLE) begin
      e_d = end_bit ? 6'd0 : e_q + 6'd1;
      if (e_q == half - 6'd1) s0_d = RX_IN;
      if (e_q == half)        s1_d = RX_IN;
      // The third capture feeds the vote directly so the result is usable at half+2.
      if (e_q == half + 6'd1) sb_d = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
    end

    case (state_q)
      IDLE: begin
        e_d = 6'd0;
        if (!RX_IN) begin
          state_d = START;
          e_d     = 6'd1;
          p_d     = p_eff;
`ifdef PARITY_CHECK_EN
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
`endif
        end
      end
      START: begin
        if (mid && sb_q) begin
          state_d = IDLE;
          e_d     = 6'd0;
        end else if (end_bit) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (end_bit) begin
          DeserEn = 1'b1;
          bit_d   = bit_q + BW'(1);
`ifdef PARITY_CHECK_EN
          acc_d = acc_q ^ sb_q;
          if (bit_q == BW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
`else
          if (bit_q == BW'(DATA_WIDTH - 1)) state_d = STOP;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (mid && (sb_q != (acc_q ^ par_typ_q))) begin
          ParErr = 1'b1;
          err_d  = 1'b1;
        end
        if (end_bit) state_d = STOP;
      end
`endif
      STOP: begin
        if (mid && !sb_q) begin
          StpErr = 1'b1;
          err_d  = 1'b1;
        end
        if (end_bit) begin
          OutData = !err_q;
          state_d = IDLE;
          bit_d   = '0;
          err_d   = 1'b0;
`ifdef PARITY_CHECK_EN
          acc_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        e_d     = 6'd0;
      end
    endcase

    dv_d = OutData;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      e_q     <= 6'd0;
      p_q     <= 6'd8;
      bit_q   <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      sb_q    <= 1'b0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      p_q     <= p_d;
      bit_q   <= bit_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      sb_q    <= sb_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q     <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
    end
  end
`endif

  assign SampledBit = sb_q;
  assign DataValid  = dv_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frame timing, voting, glitch rejection, error frames, reset abort.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       SampledBit, DeserEn, OutData, DataValid, ParErr, StpErr;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .SampledBit(SampledBit),
    .DeserEn(DeserEn), .OutData(OutData), .DataValid(DataValid),
    .ParErr(ParErr), .StpErr(StpErr)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int   deser_n = 0, out_n = 0, dv_n = 0, par_n = 0, stp_n = 0;
  int   out_cyc = 0, dv_cyc = 0, stp_cyc = 0;
  int   deser_cyc [256];
  logic deser_bit [256];

  always @(negedge CLK) begin
    if (DeserEn) begin
      if (deser_n < 256) begin
        deser_cyc[deser_n] = cyc;
        deser_bit[deser_n] = SampledBit;
      end
      deser_n++;
    end
    if (OutData)   begin out_n++; out_cyc = cyc; end
    if (DataValid) begin dv_n++;  dv_cyc  = cyc; end
    if (ParErr)    par_n++;
    if (StpErr)    begin stp_n++; stp_cyc = cyc; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] mk(input logic [7:0] d, input bit par, input bit pv, input bit stp);
    logic [11:0] f;
    f = 12'h000;
    f[8:1] = d;
    if (par) begin f[9] = pv; f[10] = stp; end
    else f[9] = stp;
    return f;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_frame(input logic [11:0] bits, input int nbits, input int p,
                             input int nk, input int ne, output int st);
    st = cyc;
    for (int k = 0; k < nbits; k++) begin
      for (int e = 0; e < p; e++) begin
        RX_IN = (k == nk && e == ne) ? ~bits[k] : bits[k];
        step(1);
      end
    end
  endtask

  task automatic test_reset;
    step(2);
    chk_cnt++;
    if ({SampledBit, DeserEn, OutData, DataValid, ParErr, StpErr} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000", {SampledBit, DeserEn, OutData, DataValid, ParErr, StpErr});
    else pass_cnt++;
    RST = 1'b0;
    step(3);
    chk_cnt++;
    if ({SampledBit, DeserEn, OutData, DataValid, ParErr, StpErr} !== 6'b0)
      $display("FAIL idle_outputs: got %b want 000000", {SampledBit, DeserEn, OutData, DataValid, ParErr, StpErr});
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    int bd;
    Prescale = 6'd16;
    bd = deser_n;
    RX_IN = 1'b0;
    step(2);
    RX_IN = 1'b1;
    step(20);
    chk_cnt++;
    if (SampledBit !== 1'b1) $display("FAIL glitch_vote: got %b want 1", SampledBit);
    else pass_cnt++;
    chk_cnt++;
    if (deser_n - bd !== 0) $display("FAIL glitch_deser: got %0d want 0", deser_n - bd);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int st, bd, bo, bv, bp, bs;
    logic exp_bits [8];
    exp_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    Prescale = 6'd8; PAR_EN = 1'b0;
    bd = deser_n; bo = out_n; bv = dv_n; bp = par_n; bs = stp_n;
    drive_frame(mk(8'hA5, 0, 0, 1), 10, 8, -1, -1, st);
    RX_IN = 1'b1;
    step(4);
    chk_cnt++;
    if (deser_n - bd !== 8) $display("FAIL a5_deser_count: got %0d want 8", deser_n - bd);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (deser_cyc[bd+i] - st !== 8*(i+1) + 7)
        $display("FAIL a5_deser_cyc[%0d]: got %0d want %0d", i, deser_cyc[bd+i] - st, 8*(i+1) + 7);
      else pass_cnt++;
      chk_cnt++;
      if (deser_bit[bd+i] !== exp_bits[i])
        $display("FAIL a5_bit[%0d]: got %b want %b", i, deser_bit[bd+i], exp_bits[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (out_n - bo !== 1 || out_cyc - st !== 79)
      $display("FAIL a5_outdata: got n=%0d cyc=%0d want n=1 cyc=79", out_n - bo, out_cyc - st);
    else pass_cnt++;
    chk_cnt++;
    if (dv_n - bv !== 1 || dv_cyc - st !== 80)
      $display("FAIL a5_datavalid: got n=%0d cyc=%0d want n=1 cyc=80", dv_n - bv, dv_cyc - st);
    else pass_cnt++;
    chk_cnt++;
    if (par_n - bp !== 0 || stp_n - bs !== 0)
      $display("FAIL a5_errors: got par=%0d stp=%0d want 0 0", par_n - bp, stp_n - bs);
    else pass_cnt++;
  endtask

  task automatic test_noise;
    int st, bd, bo;
    logic [7:0] d;
    d = 8'h5A;
    Prescale = 6'd16; PAR_EN = 1'b0;
    bd = deser_n; bo = out_n;
    drive_frame(mk(d, 0, 0, 1), 10, 16, 4, 8, st);
    RX_IN = 1'b1;
    step(4);
    chk_cnt++;
    if (deser_n - bd !== 8) $display("FAIL noise_deser_count: got %0d want 8", deser_n - bd);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (deser_bit[bd+i] !== d[i])
        $display("FAIL noise_bit[%0d]: got %b want %b", i, deser_bit[bd+i], d[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (out_n - bo !== 1 || out_cyc - st !== 159)
      $display("FAIL noise_outdata: got n=%0d cyc=%0d want n=1 cyc=159", out_n - bo, out_cyc - st);
    else pass_cnt++;
  endtask

  task automatic test_parity;
    int st, bo, bv, bp;
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
`ifdef PARITY_CHECK_EN
    bo = out_n; bv = dv_n; bp = par_n;
    drive_frame(mk(8'h03, 1, 0, 1), 11, 16, -1, -1, st);
    RX_IN = 1'b1;
    step(4);
    chk_cnt++;
    if (out_n - bo !== 1 || out_cyc - st !== 175)
      $display("FAIL par_good_outdata: got n=%0d cyc=%0d want n=1 cyc=175", out_n - bo, out_cyc - st);
    else pass_cnt++;
    chk_cnt++;
    if (par_n - bp !== 0) $display("FAIL par_good_parerr: got %0d want 0", par_n - bp);
    else pass_cnt++;
    bo = out_n; bv = dv_n; bp = par_n;
    drive_frame(mk(8'h03, 1, 1, 1), 11, 16, -1, -1, st);
    RX_IN = 1'b1;
    step(4);
    chk_cnt++;
    if (par_n - bp !== 1) $display("FAIL par_bad_parerr: got %0d want 1", par_n - bp);
    else pass_cnt++;
    chk_cnt++;
    if (out_n - bo !== 0 || dv_n - bv !== 0)
      $display("FAIL par_bad_strobes: got out=%0d dv=%0d want 0 0", out_n - bo, dv_n - bv);
    else pass_cnt++;
    PAR_TYP = 1'b1;
    bo = out_n; bp = par_n;
    drive_frame(mk(8'h03, 1, 1, 1), 11, 16, -1, -1, st);
    RX_IN = 1'b1;
    step(4);
    chk_cnt++;
    if (out_n - bo !== 1 || par_n - bp !== 0)
      $display("FAIL par_odd_good: got out=%0d par=%0d want 1 0", out_n - bo, par_n - bp);
    else pass_cnt++;
`else
    bo = out_n; bv = dv_n; bp = par_n;
    drive_frame(mk(8'h03, 0, 0, 1), 10, 16, -1, -1, st);
    RX_IN = 1'b1;
    step(4);
    chk_cnt++;
    if (out_n - bo !== 1 || out_cyc - st !== 159)
      $display("FAIL nopar_outdata: got n=%0d cyc=%0d want n=1 cyc=159", out_n - bo, out_cyc - st);
    else pass_cnt++;
    chk_cnt++;
    if (par_n - bp !== 0 || dv_n - bv !== 1)
      $display("FAIL nopar_flags: got par=%0d dv=%0d want 0 1", par_n - bp, dv_n - bv);
    else pass_cnt++;
`endif
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
  endtask

  task automatic test_back_to_back;
    int st1, st2, bd, bo, bs;
    logic [7:0] d2;
    d2 = 8'h3C;
    Prescale = 6'd8;
    bd = deser_n; bo = out_n; bs = stp_n;
    drive_frame(mk(8'hC3, 0, 0, 0), 10, 8, -1, -1, st1);
    drive_frame(mk(d2, 0, 0, 1), 10, 8, -1, -1, st2);
    RX_IN = 1'b1;
    step(4);
    chk_cnt++;
    if (stp_n - bs !== 1 || stp_cyc - st1 !== 78)
      $display("FAIL stperr: got n=%0d cyc=%0d want n=1 cyc=78", stp_n - bs, stp_cyc - st1);
    else pass_cnt++;
    chk_cnt++;
    if (out_n - bo !== 1 || out_cyc - st2 !== 79)
      $display("FAIL b2b_outdata: got n=%0d cyc=%0d want n=1 cyc=79", out_n - bo, out_cyc - st2);
    else pass_cnt++;
    chk_cnt++;
    if (deser_n - bd !== 16) $display("FAIL b2b_deser_count: got %0d want 16", deser_n - bd);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (deser_bit[bd+8+i] !== d2[i])
        $display("FAIL b2b_bit[%0d]: got %b want %b", i, deser_bit[bd+8+i], d2[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_prescale5;
    int st, bo;
    Prescale = 6'd5;
    bo = out_n;
    drive_frame(mk(8'hA5, 0, 0, 1), 10, 8, -1, -1, st);
    RX_IN = 1'b1;
    step(4);
    chk_cnt++;
    if (out_n - bo !== 1 || out_cyc - st !== 79)
      $display("FAIL p5_outdata: got n=%0d cyc=%0d want n=1 cyc=79", out_n - bo, out_cyc - st);
    else pass_cnt++;
    Prescale = 6'd8;
  endtask

  task automatic test_reset_mid;
    int st, bd, bo;
    logic [7:0] d;
    d = 8'h96;
    Prescale = 6'd8;
    bd = deser_n; bo = out_n;
    RX_IN = 1'b0;
    step(8);
    RX_IN = 1'b1;
    step(36);
    chk_cnt++;
    if (SampledBit !== 1'b1) $display("FAIL rst_pre_vote: got %b want 1", SampledBit);
    else pass_cnt++;
    #3 RST = 1'b1;
    #1;
    chk_cnt++;
    if ({SampledBit, DeserEn, OutData, DataValid, ParErr, StpErr} !== 6'b0)
      $display("FAIL rst_async_outputs: got %b want 000000", {SampledBit, DeserEn, OutData, DataValid, ParErr, StpErr});
    else pass_cnt++;
    step(1);
    RST = 1'b0;
    step(3);
    chk_cnt++;
    if (deser_n - bd !== 4 || out_n - bo !== 0)
      $display("FAIL rst_aborted: got deser=%0d out=%0d want 4 0", deser_n - bd, out_n - bo);
    else pass_cnt++;
    bd = deser_n; bo = out_n;
    drive_frame(mk(d, 0, 0, 1), 10, 8, -1, -1, st);
    RX_IN = 1'b1;
    step(4);
    chk_cnt++;
    if (out_n - bo !== 1 || out_cyc - st !== 79)
      $display("FAIL rst_after_outdata: got n=%0d cyc=%0d want n=1 cyc=79", out_n - bo, out_cyc - st);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (deser_bit[bd+i] !== d[i])
        $display("FAIL rst_after_bit[%0d]: got %b want %b", i, deser_bit[bd+i], d[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_basic();
    test_noise();
    test_parity();
    test_back_to_back();
    test_prescale5();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART RX path. It watches the serial line, oversamples each bit with a prescale counter and takes a 3-sample majority vote at mid-bit. It drives the byte deserializer's SampledBit/Enable/OutData controls, checks start, parity and stop bits, and flags the received byte as valid or erroneous. It sits between the RX pin synchronizer and the deserializer in the UART receive channel.

## Interface
- Parameters:
- DATA_WIDTH, 8, data bits per frame; also the number of deserializer shift pulses.
- Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  receive oversampling clock.
- RST  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line, already synchronized; idles high.
- Prescale  in  6  oversampling ratio; legal values are 8, 16 and 32.
- PAR_EN  in  1  parity bit present in the frame.
- PAR_TYP  in  1  parity type: 0 even, 1 odd.
- SampledBit  out  1  majority-voted bit value; goes to the deserializer.
- DeserEn  out  1  one-cycle shift strobe per data bit; goes to the deserializer Enable input.
- OutData  out  1  one-cycle load strobe for a good frame; goes to the deserializer.
- DataValid  out  1  one-cycle pulse, one cycle after OutData, when the deserializer PData is updated.
- ParErr  out  1  one-cycle pulse on parity mismatch.
- StpErr  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- Reset values: all outputs 0. The FSM is in IDLE, and the edge counter, bit counter, sample registers and parity accumulator are all 0.
- Effective prescale P is Prescale when it is 8, 16 or 32, and 8 for any other value. P is latched on leaving IDLE and held for the whole frame.
- Edge counter e runs 0..P-1 within each bit and wraps to 0 at the bit boundary.
- Sampling: RX_IN is captured at e = P/2-1, P/2 and P/2+1. SampledBit is the majority of the three captures. It updates at e = P/2+2 and holds until the next update.
- States and transitions:
- IDLE: RX_IN = 0 moves to START with e = 1, counting the detecting cycle as e = 0.
- START: at e = P/2+2, if SampledBit = 1 the start was a glitch and the FSM returns to IDLE. Otherwise, at e = P-1 it moves to DATA.
- DATA: DeserEn pulses at e = P-1 of each data bit. The parity accumulator XORs in SampledBit. After DATA_WIDTH bits it moves to PARITY if PAR_EN = 1, else to STOP.
- PARITY: expected parity = accumulator XOR PAR_TYP. A mismatch at e = P/2+2 pulses ParErr and latches a frame-error flag. At e = P-1 it moves to STOP.
- STOP: at e = P/2+2, SampledBit = 0 pulses StpErr. At e = P-1:
- OutData pulses if neither error occurred in the frame.
- The FSM returns to IDLE and clears the bit counter, accumulator and error flag.
- Error handling: a frame with an error never asserts OutData, so the deserializer keeps its previous PData.
- Mid-frame changes: PAR_EN and PAR_TYP are sampled on leaving IDLE and frozen for the frame. Prescale is also frozen.
- RST asserted at any time returns the block to its reset state on the same edge, without waiting for the clock. No strobes are issued for the aborted frame.

## Timing
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1) × P cycles, measured from the cycle RX_IN is first seen low.
- DeserEn is high for exactly DATA_WIDTH cycles per frame, spaced P cycles apart.
- OutData fires at the last cycle of the stop bit. DataValid follows one cycle later.
- Back-to-back frames: IDLE is entered for one cycle. RX_IN = 0 in that cycle starts the next frame with no lost bits.
- SampledBit at each DeserEn is the current bit's vote; the vote settles P/2-3 cycles before the strobe.
- ParErr and StpErr are each one cycle wide and occur at most once per frame.

## Configuration
- PARITY_CHECK_EN defined: the PARITY state, the parity accumulator and ParErr are present, and PAR_EN / PAR_TYP are honoured.
- PARITY_CHECK_EN undefined:
- The PARITY state and accumulator are removed.
- PAR_EN and PAR_TYP are ignored, and frames have no parity bit.
- ParErr is tied to 0.
- The ports stay present so the interface is unchanged.

## Test plan
- P = 8, PAR_EN = 0, byte 0xA5 sent LSB first with a good stop bit:
- 8 DeserEn pulses, 8 cycles apart, with SampledBit = 1,0,1,0,0,1,0,1.
- OutData at cycle 79, DataValid at cycle 80, no errors.
- P = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x03 with parity bit 0 (correct): OutData at cycle 175, ParErr = 0. The same frame with parity bit 1: ParErr pulses once, and neither OutData nor DataValid asserts.
- P = 8, stop bit driven low: StpErr pulses at e = 6 of the stop bit, there is no OutData, and the next frame starting 1 cycle later is received correctly.
- Glitch: RX_IN low for 2 cycles then high with P = 16 gives SampledBit = 1 in START and a return to IDLE, with no DeserEn ever asserted. One-sample noise in a data bit is corrected by the majority vote.
- Prescale = 5: the block behaves as P = 8. RST asserted during bit 4 of DATA: all outputs are 0 immediately and the FSM is in IDLE. After release, a following clean frame is received normally.
